// File: rtl/charbuf_console_writer.sv
`default_nettype none
// ============================================================================
//  Module      : charbuf_console_writer
//  Description : Write-side sequencer for a 64x32 colour character buffer
//                (2048 x 16b, {attr, char}). Turns a byte stream into buffer
//                writes at a hardware cursor, handling CR, LF, BS and
//                form-feed / clear_req window clears.
//                Optional feature macro: CHARBUF_LINE_ERASE_EN
//                (blank each new row on a row advance).
//  Revision    : 1.0 - initial release
// ============================================================================
module charbuf_console_writer #(
  parameter int         COLS       = 60,
  parameter int         ROWS       = 17,
  parameter logic [7:0] CLEAR_CHAR = 8'h20,
  parameter logic [7:0] CLEAR_ATTR = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic [7:0]  in_attr,
  input  logic        clear_req,
  output logic        busy,
  output logic        clear_done,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        wr_ce,
  output logic [10:0] wr_addr,
  output logic [15:0] wr_data
);

  localparam logic [5:0]  COL_LAST = 6'(COLS - 1);
  localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);
  localparam logic [15:0] BLANK    = {CLEAR_ATTR, CLEAR_CHAR};

  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_FF = 8'h0C;
  localparam logic [7:0] CODE_CR = 8'h0D;

`ifdef CHARBUF_LINE_ERASE_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_ERASE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [5:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  // Fill counters walk the cells written by CLEAR (and ERASE when built).
  logic [5:0]  fill_col_q, fill_col_d;
  logic [4:0]  fill_row_q, fill_row_d;
  logic        wr_ce_q, wr_ce_d;
  logic [10:0] wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  // last_q marks the cycle the final clear write is on the port;
  // clear_done follows it by one cycle.
  logic        last_q, last_d;
  logic        clear_done_q;

  logic        accept;
  logic [4:0]  row_adv;

  assign in_ready = (state_q == S_IDLE) & ~clear_req;
  assign accept   = in_valid & in_ready;
  // Row advance wraps to the top; there is no scrolling.
  assign row_adv  = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;

  // Next-state, cursor and write-port decode.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    fill_col_d = fill_col_q;
    fill_row_d = fill_row_q;
    wr_ce_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    last_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d    = S_CLEAR;
          fill_col_d = 6'd0;
          fill_row_d = 5'd0;
          col_d      = 6'd0;
          row_d      = 5'd0;
        end else if (accept) begin
          case (in_data)
            CODE_CR: col_d = 6'd0;
            CODE_LF: begin
              row_d = row_adv;
`ifdef CHARBUF_LINE_ERASE_EN
              state_d    = S_ERASE;
              fill_row_d = row_adv;
              fill_col_d = 6'd0;
`endif
            end
            CODE_BS: begin
              // Backspace at column 0 is a no-op.
              if (col_q != 6'd0) begin
                col_d     = col_q - 6'd1;
                wr_ce_d   = 1'b1;
                wr_addr_d = {row_q, col_q - 6'd1};
                wr_data_d = BLANK;
              end
            end
            CODE_FF: begin
              state_d    = S_CLEAR;
              fill_col_d = 6'd0;
              fill_row_d = 5'd0;
              col_d      = 6'd0;
              row_d      = 5'd0;
            end
            default: begin
              wr_ce_d   = 1'b1;
              wr_addr_d = {row_q, col_q};
              wr_data_d = {in_attr, in_data};
              if (col_q == COL_LAST) begin
                col_d = 6'd0;
                row_d = row_adv;
`ifdef CHARBUF_LINE_ERASE_EN
                state_d    = S_ERASE;
                fill_row_d = row_adv;
                fill_col_d = 6'd0;
`endif
              end else begin
                col_d = col_q + 6'd1;
              end
            end
          endcase
        end
      end

      S_CLEAR: begin
        if (clear_req) begin
          // Restart from the top-left; no write this cycle.
          fill_col_d = 6'd0;
          fill_row_d = 5'd0;
        end else begin
          wr_ce_d   = 1'b1;
          wr_addr_d = {fill_row_q, fill_col_q};
          wr_data_d = BLANK;
          if (fill_col_q == COL_LAST) begin
            fill_col_d = 6'd0;
            if (fill_row_q == ROW_LAST) begin
              state_d    = S_IDLE;
              fill_row_d = 5'd0;
              last_d     = 1'b1;
            end else begin
              fill_row_d = fill_row_q + 5'd1;
            end
          end else begin
            fill_col_d = fill_col_q + 6'd1;
          end
        end
      end

`ifdef CHARBUF_LINE_ERASE_EN
      S_ERASE: begin
        if (clear_req) begin
          state_d    = S_CLEAR;
          fill_col_d = 6'd0;
          fill_row_d = 5'd0;
          col_d      = 6'd0;
          row_d      = 5'd0;
        end else begin
          wr_ce_d   = 1'b1;
          wr_addr_d = {fill_row_q, fill_col_q};
          wr_data_d = BLANK;
          if (fill_col_q == COL_LAST) begin
            state_d    = S_IDLE;
            fill_col_d = 6'd0;
          end else begin
            fill_col_d = fill_col_q + 6'd1;
          end
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // State, cursor and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      col_q        <= 6'd0;
      row_q        <= 5'd0;
      fill_col_q   <= 6'd0;
      fill_row_q   <= 5'd0;
      wr_ce_q      <= 1'b0;
      wr_addr_q    <= 11'd0;
      wr_data_q    <= 16'd0;
      last_q       <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      fill_col_q   <= fill_col_d;
      fill_row_q   <= fill_row_d;
      wr_ce_q      <= wr_ce_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      last_q       <= last_d;
      clear_done_q <= last_q;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign clear_done = clear_done_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign wr_ce      = wr_ce_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule
`default_nettype wire
